md_unit: RTL and testbench

//   E-stage multiply/divide unit with architectural HI/LO registers; consumes HILO_type from the decoder.

---
 rtl/md_unit.sv | 130 +++++++++++++
 tb/tb_md_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers for the E stage.
// Multi-cycle mult/div; single-cycle mthi/mtlo; mfhi/mflo read combinationally.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  HILO_type,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] HILO_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;
    logic [31:0]    thi_q, thi_d, tlo_q, tlo_d;

    logic           is_md;
    logic [63:0]    prod_s, prod_u;
    logic [31:0]    quo_s, rem_s, quo_u, rem_u;

    assign is_md  = (HILO_type == OP_MULT) || (HILO_type == OP_MULTU) ||
                    (HILO_type == OP_DIV)  || (HILO_type == OP_DIVU);
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    // SV signed division truncates toward zero and the remainder takes the dividend's sign.
    assign quo_s  = $signed(A) / $signed(B);
    assign rem_s  = $signed(A) % $signed(B);
    assign quo_u  = A / B;
    assign rem_u  = A % B;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            thi_q   <= '0;
            tlo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            thi_q   <= thi_d;
            tlo_q   <= tlo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        thi_d   = thi_q;
        tlo_d   = tlo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    // Divide by zero re-latches the current HI/LO so completion leaves them intact.
                    case (HILO_type)
                        OP_MULT: begin
                            cnt_d = CW'(MULT_CYCLES);
                            {thi_d, tlo_d} = prod_s;
                        end
                        OP_MULTU: begin
                            cnt_d = CW'(MULT_CYCLES);
                            {thi_d, tlo_d} = prod_u;
                        end
                        OP_DIV: begin
                            cnt_d = CW'(DIV_CYCLES);
                            {thi_d, tlo_d} = (B == 32'd0) ? {hi_q, lo_q} : {rem_s, quo_s};
                        end
                        default: begin
                            cnt_d = CW'(DIV_CYCLES);
                            {thi_d, tlo_d} = (B == 32'd0) ? {hi_q, lo_q} : {rem_u, quo_u};
                        end
                    endcase
                end else if (!req && HILO_type == OP_MTHI) begin
                    hi_d = A;
                end else if (!req && HILO_type == OP_MTLO) begin
                    lo_d = A;
                end
            end
            S_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    hi_d    = thi_q;
                    lo_d    = tlo_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == S_BUSY);
        start = is_md && !busy && !req;
        if (HILO_type == OP_MFHI)
            HILO_out = hi_q;
        else if (HILO_type == OP_MFLO)
            HILO_out = lo_q;
        else
            HILO_out = 32'd0;
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus random ops against a cycle-level HI/LO model.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;
    localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MFLO = 4'd5, MFHI = 4'd6, MTLO = 4'd7, MTHI = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  HILO_type;
    logic [31:0] A, B;
    logic        req;
    logic        start, busy;
    logic [31:0] HILO_out;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .HILO_type(HILO_type), .A(A), .B(B), .req(req),
        .start(start), .busy(busy), .HILO_out(HILO_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: architectural HI/LO, remaining busy cycles, pending result.
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_cnt = 0;
    logic        obs_start, obs_busy;
    logic [31:0] obs_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compute(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint p, ma, mb, q, r;
        longint unsigned pu;
        sa = a;
        sb = b;
        p_hi = m_hi;
        p_lo = m_lo;
        case (t)
            MULT: begin
                p = longint'(sa) * longint'(sb);
                p_hi = p[63:32];
                p_lo = p[31:0];
            end
            MULTU: begin
                pu = {32'd0, a} * {32'd0, b};
                p_hi = pu[63:32];
                p_lo = pu[31:0];
            end
            DIV: if (b != 0) begin
                ma = (sa < 0) ? -longint'(sa) : longint'(sa);
                mb = (sb < 0) ? -longint'(sb) : longint'(sb);
                q  = ma / mb;
                if ((sa < 0) != (sb < 0)) q = -q;
                r  = longint'(sa) - q * longint'(sb);
                p_lo = q[31:0];
                p_hi = r[31:0];
            end
            default: if (b != 0) begin
                p_lo = a / b;
                p_hi = a % b;
            end
        endcase
    endtask

    // One clock cycle: drive after posedge, compare at negedge, advance the model across the edge.
    task automatic step(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b, input logic r);
        logic        e_start;
        logic [31:0] e_out;
        HILO_type = t; A = a; B = b; req = r;
        @(negedge clk);
        e_start = (t >= MULT && t <= DIVU) && (m_cnt == 0) && !r;
        e_out   = (t == MFHI) ? m_hi : (t == MFLO) ? m_lo : 32'd0;
        check("start", {31'd0, start}, {31'd0, e_start});
        check("busy", {31'd0, busy}, {31'd0, m_cnt != 0});
        check("hilo_out", HILO_out, e_out);
        obs_start = start; obs_busy = busy; obs_out = HILO_out;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (e_start) begin
            m_cnt = (t == MULT || t == MULTU) ? MC : DC;
            compute(t, a, b);
        end else if (!r && t == MTHI) begin
            m_hi = a;
        end else if (!r && t == MTLO) begin
            m_lo = a;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b, output int nbusy);
        step(t, a, b, 1'b0);
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            step(NONE, 32'd0, 32'd0, 1'b0);
            if (!obs_busy) break;
            nbusy++;
        end
    endtask

    task automatic rd(input logic [3:0] t, output logic [31:0] v);
        step(t, 32'd0, 32'd0, 1'b0);
        v = obs_out;
    endtask

    initial begin
        int          nb;
        logic [31:0] v, hi0, lo0;
        logic [3:0]  t;
        logic [31:0] a, b;
        logic        r;

        reset = 1'b1; HILO_type = MFHI; A = 0; B = 0; req = 0;
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HILO_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // mult / multu of 0xFFFFFFFF * 2
        run_op(MULT, 32'hFFFFFFFF, 32'd2, nb);
        check("mult_busy_cycles", nb, MC);
        rd(MFHI, v); check("mult_hi", v, 32'hFFFFFFFF);
        rd(MFLO, v); check("mult_lo", v, 32'hFFFFFFFE);
        run_op(MULTU, 32'hFFFFFFFF, 32'd2, nb);
        check("multu_busy_cycles", nb, MC);
        rd(MFHI, v); check("multu_hi", v, 32'h00000001);
        rd(MFLO, v); check("multu_lo", v, 32'hFFFFFFFE);

        // signed and unsigned divide
        run_op(DIV, 32'hFFFFFFF9, 32'd2, nb);
        check("div_busy_cycles", nb, DC);
        rd(MFLO, v); check("div_lo", v, 32'hFFFFFFFD);
        rd(MFHI, v); check("div_hi", v, 32'hFFFFFFFF);
        run_op(DIVU, 32'd7, 32'd2, nb);
        rd(MFLO, v); check("divu_lo", v, 32'd3);
        rd(MFHI, v); check("divu_hi", v, 32'd1);

        // divide by zero keeps HI/LO
        step(MTHI, 32'h12, 32'd0, 1'b0);
        step(MTLO, 32'h34, 32'd0, 1'b0);
        run_op(DIV, 32'd5, 32'd0, nb);
        check("div0_busy_cycles", nb, DC);
        rd(MFHI, v); check("div0_hi", v, 32'h12);
        rd(MFLO, v); check("div0_lo", v, 32'h34);

        // flush request blocks start and mt writes
        rd(MFHI, hi0); rd(MFLO, lo0);
        step(MULT, 32'd3, 32'd4, 1'b1);
        check("req_start", {31'd0, obs_start}, 32'd0);
        step(NONE, 32'd0, 32'd0, 1'b0);
        check("req_busy", {31'd0, obs_busy}, 32'd0);
        step(MTLO, 32'hAA, 32'd0, 1'b1);
        rd(MFLO, v); check("req_mtlo_lo", v, lo0);
        rd(MFHI, v); check("req_mult_hi", v, hi0);

        // mt and md ops presented while busy are ignored
        step(MULT, 32'd6, 32'd7, 1'b0);
        step(MTHI, 32'hDEAD, 32'd0, 1'b0);
        step(DIVU, 32'd9, 32'd3, 1'b0);
        check("busy_start", {31'd0, obs_start}, 32'd0);
        for (int i = 0; i < MC; i++) step(NONE, 32'd0, 32'd0, 1'b0);
        rd(MFLO, v); check("busy_ignore_lo", v, 32'd42);

        // asynchronous reset mid-divide
        step(MTHI, 32'h55, 32'd0, 1'b0);
        step(DIV, 32'd100, 32'd7, 1'b0);
        step(NONE, 32'd0, 32'd0, 1'b0);
        step(NONE, 32'd0, 32'd0, 1'b0);
        HILO_type = MFHI;
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", HILO_out, 32'd0);
        m_cnt = 0; m_hi = 0; m_lo = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < DC + 2; i++) step((i % 2) ? MFLO : MFHI, 32'd0, 32'd0, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            t = 4'($urandom_range(0, 8));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            r = ($urandom_range(0, 7) == 0);
            step(t, a, b, r);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
